// File: rtl/clock_generation_mc_pkg.sv
// Shared types for the clks_alot clock generators: per-channel configuration,
// clock state bundle handed to the protocol engines, and small helpers.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH = 8;

  typedef struct packed {
    logic [RATE_COUNTER_WIDTH-1:0] half_period;
    logic                          idle_level;
    logic                          pause_polarity;
  } chan_cfg_s;

  typedef struct packed {
    logic                          clk;
    logic                          rise;
    logic                          fall;
    logic                          locked;
    logic                          pause_active;
    logic [RATE_COUNTER_WIDTH-1:0] pause_duration;
  } clock_states_s;

  typedef enum logic {
    PS_RUN    = 1'b0,
    PS_PAUSED = 1'b1
  } pause_state_e;

  // Index width for addressing one of n channels; never narrower than 1 bit.
  function automatic int CHAN_IDX_WIDTH(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_gen_channel.sv
// One clock channel: half-period divider, glitch-free pause FSM with duration
// counter, registered edge events and lock status.
module clock_gen_channel
  import clks_alot_p::*;
#(
  parameter int CNT_W = clks_alot_p::RATE_COUNTER_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  chan_cfg_s     cfg_i,
  input  logic          enable_i,
  input  logic          pause_en_i,
  output clock_states_s unpausable_o,
  output clock_states_s pausable_o
);

  localparam int SW = RATE_COUNTER_WIDTH;

  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             pclk_q, pclk_d;
  pause_state_e     st_q, st_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             locked_q, locked_d;
  logic             urise_q, urise_d, ufall_q, ufall_d;
  logic             prise_q, prise_d, pfall_q, pfall_d;

  logic [CNT_W-1:0] hp_lo, hp_m1;
  logic             expiry, qual;
  logic             unused_hp;

  // Only the low CNT_W bits of the configured half period are meaningful.
  assign hp_lo     = cfg_i.half_period[CNT_W-1:0];
  assign hp_m1     = (hp_lo == '0) ? '0 : hp_lo - CNT_W'(1);
  assign unused_hp = ^cfg_i.half_period;

  always_comb begin
    en_d     = en_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    pclk_d   = pclk_q;
    st_d     = st_q;
    dur_d    = dur_q;
    locked_d = locked_q;
    expiry   = 1'b0;
    qual     = 1'b0;
    if (clk_en) begin
      en_d = enable_i;
      if (!enable_i) begin
        cnt_d    = '0;
        clk_d    = cfg_i.idle_level;
        pclk_d   = cfg_i.idle_level;
        st_d     = PS_RUN;
        dur_d    = '0;
        locked_d = 1'b0;
      end else if (!en_q) begin
        cnt_d  = hp_m1;
        pclk_d = clk_q;
      end else begin
        expiry = (cnt_q == '0);
        if (expiry) begin
          clk_d    = ~clk_q;
          cnt_d    = hp_m1;
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (st_q == PS_RUN) pclk_d = clk_q;
        // Enter/leave only on the pause level with no toggle pending, so the
        // pausable copy freezes at pause_polarity without a runt pulse.
        qual = (clk_q == cfg_i.pause_polarity) && !expiry;
        case (st_q)
          PS_RUN: begin
            if (pause_en_i && qual) begin
              st_d  = PS_PAUSED;
              dur_d = '0;
            end
          end
          PS_PAUSED: begin
            if (expiry && (dur_q != '1)) dur_d = dur_q + CNT_W'(1);
            if (!pause_en_i && qual) st_d = PS_RUN;
          end
          default: st_d = PS_RUN;
        endcase
      end
    end
    // Level changes only happen on advancing cycles, so events self-clear.
    urise_d = clk_d & ~clk_q;
    ufall_d = ~clk_d & clk_q;
    prise_d = pclk_d & ~pclk_q;
    pfall_d = ~pclk_d & pclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      pclk_q   <= 1'b0;
      st_q     <= PS_RUN;
      dur_q    <= '0;
      locked_q <= 1'b0;
      urise_q  <= 1'b0;
      ufall_q  <= 1'b0;
      prise_q  <= 1'b0;
      pfall_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      pclk_q   <= pclk_d;
      st_q     <= st_d;
      dur_q    <= dur_d;
      locked_q <= locked_d;
      urise_q  <= urise_d;
      ufall_q  <= ufall_d;
      prise_q  <= prise_d;
      pfall_q  <= pfall_d;
    end
  end

  always_comb begin
    unpausable_o                = '0;
    unpausable_o.clk            = clk_q;
    unpausable_o.rise           = urise_q;
    unpausable_o.fall           = ufall_q;
    unpausable_o.locked         = locked_q;

    pausable_o                  = '0;
    pausable_o.clk              = pclk_q;
    pausable_o.rise             = prise_q;
    pausable_o.fall             = pfall_q;
    pausable_o.locked           = locked_q;
    pausable_o.pause_active     = (st_q == PS_PAUSED);
    pausable_o.pause_duration   = SW'(dur_q);
  end

endmodule

// File: rtl/clock_generation_mc.sv
// Multi-channel IO clock generator: CHANNELS independent dividers, each with
// its own pause control, driven from one system clock.
module clock_generation_mc #(
  parameter int CHANNELS           = 4,
  parameter int RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clk_en,
  input  clks_alot_p::chan_cfg_s     [CHANNELS-1:0] chan_cfg_i,
  input  logic                       [CHANNELS-1:0] enable_i,
  input  logic                       [CHANNELS-1:0] pause_en_i,
  output clks_alot_p::clock_states_s [CHANNELS-1:0] unpausable_state_o,
  output clks_alot_p::clock_states_s [CHANNELS-1:0] pausable_state_o
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clock_gen_channel #(
      .CNT_W(RATE_COUNTER_WIDTH)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .cfg_i       (chan_cfg_i[g]),
      .enable_i    (enable_i[g]),
      .pause_en_i  (pause_en_i[g]),
      .unpausable_o(unpausable_state_o[g]),
      .pausable_o  (pausable_state_o[g])
    );
  end

endmodule

// File: tb/tb_clock_generation_mc.sv
// Directed bench for clock_generation_mc: reset, divider timing, clk_en
// throttling, channel independence, pause, saturation, disable and reset.
module tb_clock_generation_mc;
  import clks_alot_p::*;

  localparam int CH = 2;
  localparam int CW = 4;

  logic                     clk    = 1'b0;
  logic                     rst_n  = 1'b1;
  logic                     clk_en = 1'b1;
  chan_cfg_s     [CH-1:0]   cfg;
  logic          [CH-1:0]   en;
  logic          [CH-1:0]   pen;
  clock_states_s [CH-1:0]   us;
  clock_states_s [CH-1:0]   ps;

  int vectors     = 0;
  int miscompares = 0;

  clock_generation_mc #(
    .CHANNELS          (CH),
    .RATE_COUNTER_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_en            (clk_en),
    .chan_cfg_i        (cfg),
    .enable_i          (en),
    .pause_en_i        (pen),
    .unpausable_state_o(us),
    .pausable_state_o  (ps)
  );

  always #5 clk = ~clk;

  // Free-running level after advancing edge e when enabled at edge 0.
  function automatic logic mclk(input int e, input int hp);
    if (e < hp) return 1'b0;
    return (((e - hp) / hp) % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int hp, input logic idle, input logic pol);
    cfg[ch].half_period    = RATE_COUNTER_WIDTH'(hp);
    cfg[ch].idle_level     = idle;
    cfg[ch].pause_polarity = pol;
  endtask

  initial begin
    cfg = '0;
    en  = '0;
    pen = '0;
    set_cfg(0, 3, 1'b0, 1'b1);
    set_cfg(1, 3, 1'b0, 1'b1);

    // Reset state
    #1 rst_n = 1'b0;
    #1 chkw("reset_state", 64'({us, ps}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chkw("idle_after_reset", 64'({us, ps}), 64'd0);

    // Divider hp=3, enable registered at edge 0
    en[0] = 1'b1;
    tick();
    chk("div_e0_clk", us[0].clk, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("div_clk_e%0d", e), us[0].clk, mclk(e, 3));
      chk($sformatf("div_rise_e%0d", e), us[0].rise, (e >= 3) && ((e - 3) % 6 == 0));
      chk($sformatf("div_fall_e%0d", e), us[0].fall, (e >= 6) && ((e - 6) % 6 == 0));
      chk($sformatf("div_pclk_e%0d", e), ps[0].clk, mclk(e - 1, 3));
      chk($sformatf("div_locked_e%0d", e), us[0].locked, e >= 3);
    end
    chk("div_ch1_idle", us[1].clk, 1'b0);

    // clk_en alternating: 12-cycle period
    en[0] = 1'b0;
    tick();
    chk("dis_locked", us[0].locked, 1'b0);
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      int a;
      clk_en = (k % 2 == 1);
      a = (k + 1) / 2;
      tick();
      chk($sformatf("cken_clk_e%0d", k), us[0].clk, mclk(a, 3));
      chk($sformatf("cken_rise_e%0d", k), us[0].rise,
          (k % 2 == 1) && (a >= 3) && ((a - 3) % 6 == 0));
    end
    clk_en = 1'b1;

    // Independence: ch0 hp=2, ch1 hp=5 then half_period=0
    en = '0;
    tick();
    set_cfg(0, 2, 1'b0, 1'b1);
    set_cfg(1, 5, 1'b0, 1'b1);
    en = 2'b11;
    tick();
    for (int e = 1; e <= 20; e++) begin
      if (e == 8) cfg[1].half_period = '0;
      tick();
      chk($sformatf("ind_ch0_e%0d", e), us[0].clk, mclk(e, 2));
      chk($sformatf("ind_ch1_e%0d", e), us[1].clk, (e < 10) ? mclk(e, 5) : (e % 2 == 1));
    end

    // Pause, polarity 1, requested while the clock is low
    en = '0;
    tick();
    set_cfg(0, 3, 1'b0, 1'b1);
    en = 2'b01;
    tick();
    for (int e = 1; e <= 19; e++) begin
      int exp_dur;
      pen[0] = (e <= 12);
      tick();
      exp_dur = (e < 6) ? 0 : (e < 9) ? 1 : (e < 12) ? 2 : (e < 15) ? 3 : 4;
      chk($sformatf("pau_uclk_e%0d", e), us[0].clk, mclk(e, 3));
      chk($sformatf("pau_pclk_e%0d", e), ps[0].clk, (e >= 4) && (e <= 18));
      chk($sformatf("pau_act_e%0d", e), ps[0].pause_active, (e >= 4) && (e <= 15));
      chkn($sformatf("pau_dur_e%0d", e), int'(ps[0].pause_duration), exp_dur);
      chk($sformatf("pau_prise_e%0d", e), ps[0].rise, e == 4);
      chk($sformatf("pau_pfall_e%0d", e), ps[0].fall, e == 19);
    end
    chkn("pau_unp_dur", int'(us[0].pause_duration), 0);

    // Disable while paused with both clocks high
    for (int e = 20; e <= 28; e++) begin
      pen[0] = 1'b1;
      tick();
    end
    chk("dis_pre_uclk", us[0].clk, 1'b1);
    chk("dis_pre_pclk", ps[0].clk, 1'b1);
    chk("dis_pre_act", ps[0].pause_active, 1'b1);
    chkn("dis_pre_dur", int'(ps[0].pause_duration), 2);
    en[0]  = 1'b0;
    pen[0] = 1'b0;
    tick();
    chk("dis_uclk", us[0].clk, 1'b0);
    chk("dis_pclk", ps[0].clk, 1'b0);
    chk("dis_act", ps[0].pause_active, 1'b0);
    chkn("dis_dur", int'(ps[0].pause_duration), 0);
    chk("dis_lock", ps[0].locked, 1'b0);

    // Saturation: enter with hp=2, then run hp=1 while paused
    set_cfg(1, 2, 1'b0, 1'b1);
    en[1]  = 1'b1;
    pen[1] = 1'b1;
    tick();
    for (int e = 1; e <= 30; e++) begin
      if (e == 4) cfg[1].half_period = RATE_COUNTER_WIDTH'(1);
      tick();
      if (e == 3)  chk("sat_entry", ps[1].pause_active, 1'b1);
      if (e == 17) chkn("sat_dur_e17", int'(ps[1].pause_duration), 14);
      if (e == 18) chkn("sat_dur_e18", int'(ps[1].pause_duration), 15);
    end
    chkn("sat_dur_e30", int'(ps[1].pause_duration), 15);
    chk("sat_pclk", ps[1].clk, 1'b1);
    chk("sat_ch0_idle", us[0].clk, 1'b0);

    // Reset mid-pause, mid-cycle, with clocks high
    tick();
    chk("rst_pre_uclk", us[1].clk, 1'b1);
    #3;
    rst_n = 1'b0;
    en    = '0;
    pen   = '0;
    #1 chkw("rst_async", 64'({us, ps}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chkw($sformatf("rst_hold_%0d", e), 64'({us, ps}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_generation_mc.md
# clock_generation_mc

- Multi-channel, self-timed successor to the single-channel clock generator: CHANNELS independent IO clocks from one system clock.
- Each channel has its own half-period divider, idle level, glitch-free pause with a pause-duration counter, edge events and lock status.
- Sits between the clks_alot configuration registers and the protocol engines that consume per-channel clock state.

## Interface
- CHANNELS, default 4: number of independent clock channels.
- RATE_COUNTER_WIDTH, default clks_alot_p::RATE_COUNTER_WIDTH: width of the half-period divider and the pause-duration counter.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous and active-low.
- clk_en  input  1  global advance qualifier; when low, all state holds and all event outputs are 0.
- chan_cfg_i  input  CHANNELS x clks_alot_p::chan_cfg_s  per-channel fields: half_period (RATE_COUNTER_WIDTH), idle_level (1), pause_polarity (1).
- enable_i  input  CHANNELS  per-channel clock active.
- pause_en_i  input  CHANNELS  per-channel pause request.
- unpausable_state_o  output  CHANNELS x clks_alot_p::clock_states_s  free-running clock, events and status.
- pausable_state_o  output  CHANNELS x clks_alot_p::clock_states_s  pausable clock, one cycle behind the free-running clock; events and status.

## Operation
- Divider per channel:
  - On an enable_i rise, cnt loads hp-1, where hp = max(half_period, 1).
  - While enabled, each clk_en cycle decrements cnt.
  - When cnt==0 (expiry), the clock toggles and cnt reloads from the current half_period. Config changes take effect at the next reload.
- Disable:
  - While enable_i is low, cnt = 0, both clocks = idle_level, pause_active = 0, pause_duration = 0.
  - Disable takes priority over toggle and over pause, and acts on the first clk_en cycle with enable_i low.
- Pausable clock register: copies the free-running clock each clk_en cycle while pause_active = 0; holds while pause_active = 1.
- Pause entry: requires all of
  - pause_en_i high, pause_active = 0
  - free-running clock == pause_polarity
  - no expiry this cycle.
  - Otherwise entry is deferred, so the pausable clock always freezes at pause_polarity with no runt pulse.
- Pause release: requires all of
  - pause_en_i low, pause_active = 1
  - free-running clock == pause_polarity
  - no expiry this cycle.
- pause_duration:
  - Cleared on pause entry.
  - Increments on each expiry while pause_active = 1; saturates at all-ones.
  - Holds its value after release until the next entry.
  - Always 0 in unpausable_state_o.
- Events (registered, one cycle wide, asserted in the same cycle the corresponding clock output first shows the new level):
  - rise / fall per output.
  - The pausable output produces no events while held.
- locked:
  - Sets on the first expiry after enable.
  - Clears when enable_i is low.
  - The pausable copy uses the same value.

## Timing
- Reset (async, immediate): all clocks 0, events 0, cnt 0, pause_active 0, pause_duration 0, locked 0.
- Enable rise registered at edge 0 with clk_en constantly high:
  - First toggle visible after edge hp.
  - Period = 2*hp clk_en cycles.
- Pausable clock = free-running clock delayed one clk_en cycle whenever unpaused.
- Pause entry latency: the pausable clock is held from the edge following the qualifying cycle.
- Simultaneous events:
  - Enable drop and expiry in the same cycle: the drop wins.
  - pause_en_i and expiry in the same cycle: entry defers to the next qualifying cycle.
- Reset mid-pause: clears everything; after reset the channel is disabled until enable_i is seen high.
- Channels share no state; an action on one channel has zero effect on the others.

## Structure
- Shared package clks_alot_p:
  - Add chan_cfg_s.
  - Reuse clock_states_s and RATE_COUNTER_WIDTH.
  - Add a CHAN_IDX_WIDTH helper, defined as $clog2(CHANNELS) with a floor of 1.
- Sub-module clock_gen_channel: one channel's divider, pause FSM (RUN, PAUSED), pausable register, event and lock logic.
- Top level: a generate loop over CHANNELS instances of clock_gen_channel.

## Test plan
- Reset: drive rst_n low mid-run with the clock high and paused. All outputs must be 0 without waiting for a clk edge, and must stay 0 until the next enable_i rise.
- Divider: CHANNELS=2, hp=3, enable at edge 0.
  - Rises at edges 3, 9, 15; fall at edge 6.
  - rise pulses exactly 1 cycle wide; locked high from edge 3.
  - With clk_en alternating 1/0, the period must become 12 cycles.
- Independence: ch0 hp=2, ch1 hp=5, then ch1 half_period=0.
  - ch0 keeps its 4-cycle period throughout.
  - ch1 changes to a 2-cycle period after its next reload.
- Pause: polarity=1, pause_en asserted while the clock is low.
  - Entry must wait for the clock high.
  - The pausable clock stays 1 for 3 hp expiries; pause_duration reads 3.
  - On pause_en low, release happens on the next high level.
  - No runt pulse; pausable events are suppressed while held.
- Saturation: hp=1, RATE_COUNTER_WIDTH=4, paused for 20 expiries. pause_duration must read 15.
- Disable mid-high: idle_level=0, disable while paused. Both clocks must read 0 one cycle later, with pause_active 0, pause_duration 0 and locked 0.
